dmem_access_ctrl: RTL and testbench

//  Multi-cycle data-memory access controller directly downstream of the MEM stage.

---
 rtl/dmem_pkg.sv | 17 +
 rtl/dmem_access_ctrl_if.sv | 33 +++
 rtl/dmem_wait_cnt.sv | 44 ++++
 rtl/dmem_access_ctrl.sv | 148 ++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory access controller.
package dmem_pkg;

  // Width of the ACCESS-phase wait counter (TIMEOUT tops out at 255)
  localparam int DMEM_CNT_W = 8;

  // Load data returned when a load is aborted
  localparam logic [15:0] DMEM_ERR_RDAT = 16'hFFFF;

  // Controller phases: wait for a request, run the memory handshake, report
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// External data-memory bus: chip select / write enable handshake with a
// completion strobe. The controller is the master, the memory the slave.
interface dmem_access_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);

  logic              mem_cs;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_adr;
  logic [DATA_W-1:0] mem_wdat;
  logic [DATA_W-1:0] mem_rdat;
  logic              mem_ready;

  modport master (
    output mem_cs,
    output mem_we,
    output mem_adr,
    output mem_wdat,
    input  mem_rdat,
    input  mem_ready
  );

  modport slave (
    input  mem_cs,
    input  mem_we,
    input  mem_adr,
    input  mem_wdat,
    output mem_rdat,
    output mem_ready
  );

endinterface

// File: rtl/dmem_wait_cnt.sv
// Counts cycles spent in ACCESS and flags when a ready strobe may be honoured
// and when the access has run out of time.
module dmem_wait_cnt
  import dmem_pkg::*;
#(
  parameter int MIN_WAIT = 1,
  parameter int TIMEOUT  = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic cnt_ge_min,
  output logic cnt_timeout
);

  localparam logic [DMEM_CNT_W-1:0] MIN_V = DMEM_CNT_W'(MIN_WAIT);
  localparam logic [DMEM_CNT_W-1:0] TMO_V = DMEM_CNT_W'(TIMEOUT - 1);

  logic [DMEM_CNT_W-1:0] cnt;

  // Clear takes priority so the count restarts at 0 on entry to ACCESS
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + DMEM_CNT_W'(1);
    end
  end

  // With no minimum wait every cycle is legal; avoids an always-true compare
  generate
    if (MIN_WAIT == 0) begin : g_no_min
      assign cnt_ge_min = 1'b1;
    end else begin : g_min
      assign cnt_ge_min = (cnt >= MIN_V);
    end
  endgenerate

  assign cnt_timeout = (cnt == TMO_V);

endmodule

// File: rtl/dmem_access_ctrl.sv
// Multi-cycle data-memory access controller behind the MEM stage. Issues one
// load or store on the external memory bus, stalls the pipeline until the
// access finishes, and returns registered load data.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int MIN_WAIT = 1,
  parameter int TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_rd,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_adr,
  input  logic [DATA_W-1:0] req_wdat,
  output logic              stall,
  output logic [DATA_W-1:0] rdat,
  output logic              rdat_valid,
  output logic              err,
  dmem_access_ctrl_if.master mem
);

  dmem_state_t state, state_nxt;

  logic              start;
  logic              complete;
  logic              abort;
  logic              cs;
  logic              cnt_ge_min;
  logic              cnt_timeout;

  logic              we_q;
  logic              is_load_q;
  logic              conflict_q;
  logic [ADDR_W-1:0] adr_q;
  logic [DATA_W-1:0] wdat_q;
  logic [DATA_W-1:0] rdat_q;
  logic              rdat_valid_q;
  logic              err_q;

  dmem_wait_cnt #(
    .MIN_WAIT (MIN_WAIT),
    .TIMEOUT  (TIMEOUT)
  ) u_wait_cnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (state != ACCESS),
    .inc         (state == ACCESS),
    .cnt_ge_min  (cnt_ge_min),
    .cnt_timeout (cnt_timeout)
  );

  // State register; reset drops straight back to IDLE even mid-access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state plus the combinational stall / chip-select decode
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    complete  = 1'b0;
    abort     = 1'b0;
    stall     = 1'b0;
    cs        = 1'b0;
    case (state)
      IDLE: begin
        if (req_rd || req_wr) begin
          start     = 1'b1;
          stall     = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        cs    = 1'b1;
        stall = 1'b1;
        if (mem.mem_ready && cnt_ge_min) begin
          complete  = 1'b1;
          state_nxt = DONE;
        end else if (cnt_timeout) begin
          abort     = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Capture the request, then the result; the status pulses are set only on
  // the edge into DONE so they last exactly that one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q         <= 1'b0;
      is_load_q    <= 1'b0;
      conflict_q   <= 1'b0;
      adr_q        <= '0;
      wdat_q       <= '0;
      rdat_q       <= '0;
      rdat_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      rdat_valid_q <= 1'b0;
      err_q        <= 1'b0;
      if (start) begin
        adr_q      <= req_adr;
        wdat_q     <= req_wdat;
        we_q       <= req_wr;
        is_load_q  <= req_rd & ~req_wr;
        conflict_q <= req_rd & req_wr;
      end
      if (complete) begin
        if (is_load_q) begin
          rdat_q <= mem.mem_rdat;
        end
        rdat_valid_q <= is_load_q;
        err_q        <= conflict_q;
      end
      if (abort) begin
        if (is_load_q) begin
          rdat_q <= '1;
        end
        rdat_valid_q <= is_load_q;
        err_q        <= 1'b1;
      end
    end
  end

  assign mem.mem_cs   = cs;
  assign mem.mem_we   = cs & we_q;
  assign mem.mem_adr  = adr_q;
  assign mem.mem_wdat = wdat_q;

  assign rdat       = rdat_q;
  assign rdat_valid = rdat_valid_q;
  assign err        = err_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl. Two instances with different
// MIN_WAIT/TIMEOUT settings share one clock and reset; each has its own
// request inputs and its own memory bus.
module tb_dmem_access_ctrl;
  import dmem_pkg::*;

  localparam int MINW0 = 1;
  localparam int TMO0  = 8;
  localparam int MINW1 = 3;
  localparam int TMO1  = 12;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  reqRd;
  logic [1:0]  reqWr;
  logic [15:0] reqAdr [2];
  logic [15:0] reqWdat [2];
  logic [1:0]  stallO;
  logic [1:0]  validO;
  logic [1:0]  errO;
  logic [15:0] rdatO [2];
  logic [1:0]  memReady;
  logic [15:0] memRdat [2];

  int          compared;
  int          mismatched;
  int          txnId;
  logic [15:0] rdatModel [2];

  typedef struct {
    logic        stall;
    logic        cs;
    logic        we;
    logic        valid;
    logic        err;
    logic [15:0] adr;
    logic [15:0] wdat;
    logic [15:0] rdat;
  } obs_t;

  typedef struct {
    int          unit;
    bit          rd;
    bit          wr;
    logic [15:0] adr;
    logic [15:0] wdat;
    logic [15:0] rdatv;
    logic [31:0] pat;
    int          gap;
    int          expAcc;
    logic [15:0] expRdat;
    bit          expValid;
    bit          expErr;
  } vec_t;

  always #5 clk = ~clk;

  dmem_access_ctrl_if #(.ADDR_W(16), .DATA_W(16)) mif0 ();
  dmem_access_ctrl_if #(.ADDR_W(16), .DATA_W(16)) mif1 ();

  assign mif0.mem_ready = memReady[0];
  assign mif0.mem_rdat  = memRdat[0];
  assign mif1.mem_ready = memReady[1];
  assign mif1.mem_rdat  = memRdat[1];

  dmem_access_ctrl #(
    .ADDR_W(16), .DATA_W(16), .MIN_WAIT(MINW0), .TIMEOUT(TMO0)
  ) dut0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_rd     (reqRd[0]),
    .req_wr     (reqWr[0]),
    .req_adr    (reqAdr[0]),
    .req_wdat   (reqWdat[0]),
    .stall      (stallO[0]),
    .rdat       (rdatO[0]),
    .rdat_valid (validO[0]),
    .err        (errO[0]),
    .mem        (mif0)
  );

  dmem_access_ctrl #(
    .ADDR_W(16), .DATA_W(16), .MIN_WAIT(MINW1), .TIMEOUT(TMO1)
  ) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_rd     (reqRd[1]),
    .req_wr     (reqWr[1]),
    .req_adr    (reqAdr[1]),
    .req_wdat   (reqWdat[1]),
    .stall      (stallO[1]),
    .rdat       (rdatO[1]),
    .rdat_valid (validO[1]),
    .err        (errO[1]),
    .mem        (mif1)
  );

  function automatic obs_t getObs(int u);
    obs_t o;
    if (u == 0) begin
      o.cs   = mif0.mem_cs;
      o.we   = mif0.mem_we;
      o.adr  = mif0.mem_adr;
      o.wdat = mif0.mem_wdat;
    end else begin
      o.cs   = mif1.mem_cs;
      o.we   = mif1.mem_we;
      o.adr  = mif1.mem_adr;
      o.wdat = mif1.mem_wdat;
    end
    o.stall = stallO[u];
    o.valid = validO[u];
    o.err   = errO[u];
    o.rdat  = rdatO[u];
    return o;
  endfunction

  // Transaction-level reference: first cycle where ready is seen at or after
  // the minimum wait wins; otherwise the access runs its full timeout window
  task automatic refTxn(input int u, input logic [31:0] pat, output int acc, output bit aborted);
    int minW;
    int tmo;
    minW    = (u == 0) ? MINW0 : MINW1;
    tmo     = (u == 0) ? TMO0 : TMO1;
    acc     = tmo;
    aborted = 1'b1;
    for (int c = 0; c < tmo; c++) begin
      if (pat[c] && c >= minW) begin
        acc     = c + 1;
        aborted = 1'b0;
        break;
      end
    end
  endtask

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s (txn %0d): got %0h, expected %0h", nm, txnId, act, exp);
    end
  endtask

  task automatic applyStimulus(input int u, input bit rd, input bit wr,
                               input logic [15:0] adr, input logic [15:0] wdat);
    reqRd[u]   = rd;
    reqWr[u]   = wr;
    reqAdr[u]  = adr;
    reqWdat[u] = wdat;
  endtask

  task automatic idleCycles(input int u, input int n);
    obs_t o;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      o = getObs(u);
      checkOutput("idle stall", o.stall, 1'b0);
      checkOutput("idle cs", o.cs, 1'b0);
      checkOutput("idle rdat_valid", o.valid, 1'b0);
      checkOutput("idle err", o.err, 1'b0);
      checkOutput("idle rdat", o.rdat, rdatModel[u]);
      @(posedge clk);
      #1;
    end
  endtask

  // One complete access: request cycle, expAcc ACCESS cycles, one DONE cycle.
  // Request lines carry junk outside IDLE to show they are ignored there.
  task automatic runTxn(input int u, input bit rd, input bit wr,
                        input logic [15:0] adr, input logic [15:0] wdat,
                        input logic [15:0] rdatv, input logic [31:0] pat,
                        input int expAcc, input logic [15:0] expRdat,
                        input bit expValid, input bit expErr);
    obs_t o;
    applyStimulus(u, rd, wr, adr, wdat);
    @(negedge clk);
    o = getObs(u);
    checkOutput("request stall", o.stall, 1'b1);
    checkOutput("request cs", o.cs, 1'b0);
    @(posedge clk);
    #1;
    for (int c = 0; c < expAcc; c++) begin
      applyStimulus(u, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
      memReady[u] = pat[c];
      memRdat[u]  = (c == expAcc - 1) ? rdatv : 16'($urandom);
      @(negedge clk);
      o = getObs(u);
      checkOutput("access stall", o.stall, 1'b1);
      checkOutput("access cs", o.cs, 1'b1);
      checkOutput("access we", o.we, wr);
      checkOutput("access adr", o.adr, adr);
      checkOutput("access wdat", o.wdat, wdat);
      checkOutput("access rdat_valid", o.valid, 1'b0);
      checkOutput("access err", o.err, 1'b0);
      @(posedge clk);
      #1;
    end
    applyStimulus(u, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
    memReady[u] = 1'($urandom);
    memRdat[u]  = 16'($urandom);
    @(negedge clk);
    o = getObs(u);
    checkOutput("done stall", o.stall, 1'b0);
    checkOutput("done cs", o.cs, 1'b0);
    checkOutput("done rdat_valid", o.valid, expValid);
    checkOutput("done err", o.err, expErr);
    checkOutput("done rdat", o.rdat, expRdat);
    @(posedge clk);
    #1;
    applyStimulus(u, 1'b0, 1'b0, 16'h0000, 16'h0000);
    memReady[u]  = 1'b0;
    rdatModel[u] = expRdat;
    txnId++;
  endtask

  initial begin
    vec_t        vecs [10];
    obs_t        o;
    int          u;
    int          kind;
    int          acc;
    int          gap;
    bit          rd;
    bit          wr;
    bit          aborted;
    bit          expValid;
    bit          expErr;
    logic [15:0] adr;
    logic [15:0] wdat;
    logic [15:0] rv;
    logic [15:0] expR;
    logic [31:0] pat;

    // unit rd wr adr wdat rdatv pat gap expAcc expRdat expValid expErr
    vecs[0] = '{0, 1'b1, 1'b0, 16'h0040, 16'h0000, 16'hBEEF, 32'h0000_0002, 1, 2,  16'hBEEF, 1'b1, 1'b0};
    vecs[1] = '{0, 1'b0, 1'b1, 16'h0010, 16'h1234, 16'h0BAD, 32'h0000_0004, 0, 3,  16'hBEEF, 1'b0, 1'b0};
    vecs[2] = '{1, 1'b1, 1'b0, 16'h0080, 16'h0000, 16'h0A5A, 32'h0000_0011, 1, 5,  16'h0A5A, 1'b1, 1'b0};
    vecs[3] = '{0, 1'b1, 1'b0, 16'h0100, 16'h0000, 16'h5555, 32'h0000_0000, 2, 8,  16'hFFFF, 1'b1, 1'b1};
    vecs[4] = '{0, 1'b1, 1'b1, 16'h0200, 16'hCAFE, 16'h9999, 32'h0000_0002, 0, 2,  16'hFFFF, 1'b0, 1'b1};
    vecs[5] = '{1, 1'b0, 1'b1, 16'h0300, 16'h00FF, 16'h4321, 32'h0000_0000, 0, 12, 16'h0A5A, 1'b0, 1'b1};
    vecs[6] = '{1, 1'b1, 1'b0, 16'h0400, 16'h0000, 16'h1357, 32'h0000_0008, 0, 4,  16'h1357, 1'b1, 1'b0};
    vecs[7] = '{1, 1'b0, 1'b1, 16'h0402, 16'h2222, 16'h6666, 32'h0000_0008, 0, 4,  16'h1357, 1'b0, 1'b0};
    vecs[8] = '{0, 1'b1, 1'b0, 16'h0500, 16'h0000, 16'h7777, 32'h0000_0080, 1, 8,  16'h7777, 1'b1, 1'b0};
    vecs[9] = '{0, 1'b1, 1'b0, 16'h0600, 16'h0000, 16'h2468, 32'hFFFF_FFFF, 0, 2,  16'h2468, 1'b1, 1'b0};

    compared     = 0;
    mismatched   = 0;
    txnId        = 0;
    rdatModel[0] = 16'h0000;
    rdatModel[1] = 16'h0000;
    memReady     = 2'b00;
    memRdat[0]   = 16'h0000;
    memRdat[1]   = 16'h0000;
    applyStimulus(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    applyStimulus(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    rst_n = 1'b0;

    #12;
    for (int i = 0; i < 2; i++) begin
      o = getObs(i);
      checkOutput("reset stall", o.stall, 1'b0);
      checkOutput("reset cs", o.cs, 1'b0);
      checkOutput("reset we", o.we, 1'b0);
      checkOutput("reset adr", o.adr, 16'h0000);
      checkOutput("reset wdat", o.wdat, 16'h0000);
      checkOutput("reset rdat_valid", o.valid, 1'b0);
      checkOutput("reset err", o.err, 1'b0);
      checkOutput("reset rdat", o.rdat, 16'h0000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] directed vector table");
    for (int i = 0; i < 10; i++) begin
      idleCycles(vecs[i].unit, vecs[i].gap);
      runTxn(vecs[i].unit, vecs[i].rd, vecs[i].wr, vecs[i].adr, vecs[i].wdat,
             vecs[i].rdatv, vecs[i].pat, vecs[i].expAcc, vecs[i].expRdat,
             vecs[i].expValid, vecs[i].expErr);
    end
    idleCycles(0, 1);

    $display("[TB] reset during ACCESS");
    applyStimulus(0, 1'b1, 1'b0, 16'h0700, 16'h0000);
    @(posedge clk);
    #1;
    applyStimulus(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    @(negedge clk);
    o = getObs(0);
    checkOutput("pre-reset cs", o.cs, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    o = getObs(0);
    checkOutput("mid-reset cs", o.cs, 1'b0);
    checkOutput("mid-reset stall", o.stall, 1'b0);
    checkOutput("mid-reset rdat", o.rdat, 16'h0000);
    checkOutput("mid-reset err", o.err, 1'b0);
    checkOutput("mid-reset adr", o.adr, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    rdatModel[0] = 16'h0000;
    rdatModel[1] = 16'h0000;
    @(posedge clk);
    #1;
    idleCycles(0, 2);
    idleCycles(1, 1);
    runTxn(0, 1'b1, 1'b0, 16'h0800, 16'h0000, 16'hA1B2, 32'h0000_0002, 2, 16'hA1B2, 1'b1, 1'b0);

    $display("[TB] randomized transactions against reference model");
    for (int i = 0; i < 60; i++) begin
      u    = $urandom_range(0, 1);
      kind = $urandom_range(0, 4);
      rd   = (kind <= 1) || (kind == 4);
      wr   = (kind >= 2);
      adr  = 16'($urandom);
      wdat = 16'($urandom);
      rv   = 16'($urandom);
      pat  = ($urandom_range(0, 3) == 0) ? 32'h0 : ($urandom & $urandom);
      gap  = $urandom_range(0, 2);
      refTxn(u, pat, acc, aborted);
      expValid = rd & ~wr;
      expErr   = aborted | (rd & wr);
      expR     = expValid ? (aborted ? DMEM_ERR_RDAT : rv) : rdatModel[u];
      idleCycles(u, gap);
      runTxn(u, rd, wr, adr, wdat, rv, pat, acc, expR, expValid, expErr);
    end
    idleCycles(0, 1);
    idleCycles(1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
